// File: rtl/asic_stream_ctrl_if.sv
// Core-side stream bus between asic_stream_ctrl (master) and the compute core (slave).
interface asic_stream_ctrl_if #(
    parameter int unsigned DW = 32
);
    logic          core_mode;
    logic [11:0]   core_scale;
    logic          core_ready;
    logic [DW-1:0] core_data;
    logic          core_valid;
    logic [DW-1:0] core_ofmap;

    modport master (
        output core_mode, core_scale, core_ready, core_data,
        input  core_valid, core_ofmap
    );

    modport slave (
        input  core_mode, core_scale, core_ready, core_data,
        output core_valid, core_ofmap
    );
endinterface

// File: rtl/asic_stream_ctrl.sv
// Inference stream controller: buffers input words, streams them to the core, collects the ofmap.
// Optional cycle counter output perf_cycles enabled by defining ASIC_CTRL_PERF_EN.
module asic_stream_ctrl #(
    parameter int unsigned DW        = 32,
    parameter int unsigned IN_DEPTH  = 1104,
    parameter int unsigned OUT_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_wr_en,
    input  logic [DW-1:0] in_wr_data,
    input  logic          start,
    input  logic          mode,
    input  logic [11:0]   scale,
    input  logic          irq_clr,
    asic_stream_ctrl_if.master core,
    input  logic [5:0]    out_rd_addr,
    output logic [DW-1:0] out_rd_data,
    output logic [10:0]   in_count,
    output logic          busy,
    output logic          irq,
    output logic          err
`ifdef ASIC_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);
    localparam int unsigned IAW = $clog2(IN_DEPTH);
    localparam int unsigned OAW = $clog2(OUT_DEPTH);
    localparam logic [10:0]  InEnd  = 11'(IN_DEPTH);
    localparam logic [OAW:0] OutEnd = (OAW + 1)'(OUT_DEPTH);
    localparam logic [OAW:0] OutOne = (OAW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StStream, StCollect, StDone} state_e;

    state_e        state;
    logic [10:0]   wr_ptr;
    logic [10:0]   rd_ptr;
    logic [OAW:0]  out_ptr;
    logic [DW-1:0] in_buf  [IN_DEPTH];
    logic [DW-1:0] out_buf [OUT_DEPTH];

    logic in_full, out_full, out_full_next, collecting;
    logic wr_ok, ofm_ok, start_ok, start_bad;

    always_comb begin
        in_full       = (wr_ptr == InEnd);
        out_full      = (out_ptr == OutEnd);
        collecting    = (state == StStream) || (state == StCollect);
        wr_ok         = in_wr_en && (state == StIdle) && !in_full;
        ofm_ok        = core.core_valid && collecting && !out_full;
        // Final ofmap word landing this edge counts as complete for the DONE transition.
        out_full_next = out_full || (ofm_ok && (out_ptr == OutEnd - OutOne));
        start_ok      = start && (state == StIdle) && in_full;
        start_bad     = start && (state == StIdle) && !in_full;
    end

    assign in_count = wr_ptr;
    assign busy     = collecting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            out_ptr         <= '0;
            irq             <= 1'b0;
            err             <= 1'b0;
            core.core_ready <= 1'b0;
            core.core_data  <= '0;
            core.core_mode  <= 1'b0;
            core.core_scale <= '0;
        end else begin
            core.core_ready <= 1'b0;
            core.core_data  <= '0;
            if (wr_ok) wr_ptr <= wr_ptr + 11'd1;
            if (ofm_ok) out_ptr <= out_ptr + OutOne;
            if ((in_wr_en && !wr_ok) || (core.core_valid && !ofm_ok) || start_bad) err <= 1'b1;

            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        state           <= StStream;
                        core.core_mode  <= mode;
                        core.core_scale <= scale;
                        core.core_ready <= 1'b1;
                        core.core_data  <= in_buf[0];
                        rd_ptr          <= 11'd1;
                    end
                end
                StStream: begin
                    if (rd_ptr == InEnd) begin
                        state <= out_full_next ? StDone : StCollect;
                    end else begin
                        core.core_ready <= 1'b1;
                        core.core_data  <= in_buf[rd_ptr[IAW-1:0]];
                        rd_ptr          <= rd_ptr + 11'd1;
                    end
                end
                StCollect: begin
                    if (out_full_next) state <= StDone;
                end
                StDone: begin
                    irq <= 1'b1;
                    if (irq_clr) begin
                        state   <= StIdle;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        out_ptr <= '0;
                        irq     <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) in_buf[wr_ptr[IAW-1:0]] <= in_wr_data;
    end

    always_ff @(posedge clk) begin
        if (ofm_ok) out_buf[out_ptr[OAW-1:0]] <= core.core_ofmap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_rd_data <= '0;
        end else if ({1'b0, out_rd_addr} < 7'(OUT_DEPTH)) begin
            out_rd_data <= out_buf[out_rd_addr[OAW-1:0]];
        end else begin
            out_rd_data <= '0;
        end
    end

`ifdef ASIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_cycles <= '0;
        end else if (collecting && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_asic_stream_ctrl.sv
// Scoreboard bench for asic_stream_ctrl: input words and ofmap words are queued as driven,
// then popped and compared as the DUT streams them to the core or returns them on reads.
module tb_asic_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_wr_en, start, mode, irq_clr;
    logic [31:0] in_wr_data;
    logic [11:0] scale;
    logic [5:0]  out_rd_addr;
    wire  [31:0] out_rd_data;
    wire  [10:0] in_count;
    wire         busy, irq, err;
`ifdef ASIC_CTRL_PERF_EN
    wire  [31:0] perf_cycles;
`endif

    asic_stream_ctrl_if #(.DW(32)) core_bus ();

    asic_stream_ctrl #(.DW(32), .IN_DEPTH(1104), .OUT_DEPTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_wr_en    (in_wr_en),
        .in_wr_data  (in_wr_data),
        .start       (start),
        .mode        (mode),
        .scale       (scale),
        .irq_clr     (irq_clr),
        .core        (core_bus),
        .out_rd_addr (out_rd_addr),
        .out_rd_data (out_rd_data),
        .in_count    (in_count),
        .busy        (busy),
        .irq         (irq),
        .err         (err)
`ifdef ASIC_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int rdy_first = 0;
    int rdy_last = 0;
    int start_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ofm_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        in_wr_en   = 1'b1;
        in_wr_data = d;
        tick();
        in_wr_en   = 1'b0;
    endtask

    // Stream monitor: every core_ready beat must carry the next queued input word.
    always @(negedge clk) begin
        if (core_bus.core_ready) begin
            check_eq("stream_word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_eq("core_data", 64'(core_bus.core_data), 64'(exp_q.pop_front()));
            if (rdy_cnt == 0) rdy_first = cyc;
            rdy_last = cyc;
            rdy_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1; in_wr_en = 1'b0; in_wr_data = '0; start = 1'b0; mode = 1'b0;
        scale = '0; irq_clr = 1'b0; out_rd_addr = '0;
        core_bus.core_valid = 1'b0;
        core_bus.core_ofmap = '0;
        repeat (3) tick();
        check_eq("rst_core_ready", 64'(core_bus.core_ready), 64'd0);
        check_eq("rst_core_data", 64'(core_bus.core_data), 64'd0);
        check_eq("rst_core_mode", 64'(core_bus.core_mode), 64'd0);
        check_eq("rst_core_scale", 64'(core_bus.core_scale), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_in_count", 64'(in_count), 64'd0);
        check_eq("rst_out_rd_data", 64'(out_rd_data), 64'd0);
        rst = 1'b0;
        tick();

        // Underfilled buffer: start must be refused with an error.
        for (int i = 0; i < 1000; i++) write_word(32'(i));
        check_eq("short_in_count", 64'(in_count), 64'd1000);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        check_eq("short_no_stream", 64'(rdy_cnt), 64'd0);
        check_eq("short_err", 64'(err), 64'd1);
        check_eq("short_busy", 64'(busy), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst2_err", 64'(err), 64'd0);
        check_eq("rst2_in_count", 64'(in_count), 64'd0);

        // Full inference; the core returns its last ofmap word 10 cycles after the last input.
        for (int i = 0; i < 1104; i++) begin
            write_word(32'(i));
            exp_q.push_back(32'(i));
        end
        check_eq("full_in_count", 64'(in_count), 64'd1104);
        check_eq("full_err", 64'(err), 64'd0);
        mode = 1'b1; scale = 12'h123;
        start = 1'b1; tick(); start = 1'b0;
        start_cyc = cyc;
        mode = 1'b0; scale = 12'h000;
        check_eq("run_core_mode", 64'(core_bus.core_mode), 64'd1);
        check_eq("run_core_scale", 64'(core_bus.core_scale), 64'h123);
        check_eq("run_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 1050; k++) begin
            start = (k == 100);
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            core_bus.core_valid = 1'b1;
            core_bus.core_ofmap = 32'hA000 + 32'(i);
            ofm_q.push_back(32'hA000 + 32'(i));
            tick();
        end
        core_bus.core_valid = 1'b0;
        check_eq("stream_len", 64'(rdy_cnt), 64'd1104);
        check_eq("stream_first_cycle", 64'(rdy_first), 64'(start_cyc));
        check_eq("stream_contiguous", 64'(rdy_last - rdy_first), 64'd1103);
        check_eq("stream_all_words", 64'(exp_q.size()), 64'd0);
        check_eq("idle_core_data", 64'(core_bus.core_data), 64'd0);
        check_eq("done_busy", 64'(busy), 64'd0);
        check_eq("late_start_no_err", 64'(err), 64'd0);
        w = 0;
        while (!irq && w < 20) begin
            tick();
            w++;
        end
        check_eq("irq_raised", 64'(irq), 64'd1);
        check_eq("irq_latency", 64'(w), 64'd1);
`ifdef ASIC_CTRL_PERF_EN
        check_eq("perf_cycles", 64'(perf_cycles), 64'd1114);
`endif
        core_bus.core_valid = 1'b1; core_bus.core_ofmap = 32'hDEAD;
        tick();
        core_bus.core_valid = 1'b0;
        check_eq("extra_ofmap_err", 64'(err), 64'd1);
        for (int i = 0; i < 64; i++) begin
            out_rd_addr = 6'(i);
            tick();
            check_eq("out_rd_data", 64'(out_rd_data), 64'(ofm_q.pop_front()));
        end
        irq_clr = 1'b1; start = 1'b1; tick(); irq_clr = 1'b0; start = 1'b0;
        check_eq("clr_irq", 64'(irq), 64'd0);
        check_eq("clr_err", 64'(err), 64'd0);
        check_eq("clr_in_count", 64'(in_count), 64'd0);
        check_eq("clr_busy", 64'(busy), 64'd0);
        check_eq("clr_mode_held", 64'(core_bus.core_mode), 64'd1);
        repeat (3) tick();
        check_eq("clr_no_restart", 64'(rdy_cnt), 64'd1104);

        // Overfill, then abort with reset in the middle of the stream.
        rdy_cnt = 0;
        for (int i = 0; i < 1104; i++) begin
            write_word(32'(i) ^ 32'h5A5A_0000);
            exp_q.push_back(32'(i) ^ 32'h5A5A_0000);
        end
        write_word(32'h0BAD_0BAD);
        check_eq("overfill_err", 64'(err), 64'd1);
        check_eq("overfill_in_count", 64'(in_count), 64'd1104);
        scale = 12'h456;
        start = 1'b1; tick(); start = 1'b0;
        repeat (500) tick();
        check_eq("abort_scale", 64'(core_bus.core_scale), 64'h456);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("abort_core_ready", 64'(core_bus.core_ready), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_in_count", 64'(in_count), 64'd0);
        check_eq("abort_err", 64'(err), 64'd0);
        check_eq("abort_scale_rst", 64'(core_bus.core_scale), 64'd0);
        exp_q.delete();
        repeat (3) tick();
        check_eq("abort_words", 64'(rdy_cnt), 64'd501);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
